// File: rtl/circuit4_pkg.sv
// rtl/circuit4_pkg.sv - shared types and constants for the circuit-4 scheduler
package circuit4_pkg;

    localparam int DATAWIDTH_DEF = 64;
    localparam int OUTWIDTH_DEF  = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_D   = 3'd1,
        S_E   = 3'd2,
        S_F   = 3'd3,
        S_CMP = 3'd4,
        S_OUT = 3'd5
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/addsub.sv
// rtl/addsub.sv - combinational shared add/subtract unit
import circuit4_pkg::*;

module addsub #(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic [DATAWIDTH-1:0] opa,
    input  logic [DATAWIDTH-1:0] opb,
    input  op_t                  op,
    output logic [DATAWIDTH-1:0] res
);

    always_comb begin
        res = (op == OP_SUB) ? (opa - opb) : (opa + opb);
    end

endmodule

// File: rtl/circuit4_sched.sv
// rtl/circuit4_sched.sv - multi-cycle circuit-4 scheduler around one shared add/sub unit
import circuit4_pkg::*;

module circuit4_sched #(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int OUTWIDTH  = OUTWIDTH_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 busy,
    output logic                 done,
    output logic [OUTWIDTH-1:0]  x,
    output logic [OUTWIDTH-1:0]  z
);

    state_t               state, next_state;
    op_t                  op;
    logic                 sel_c;
    logic [DATAWIDTH-1:0] ra, rb, rc;
    logic [DATAWIDTH-1:0] d, e, f, g, h;
    logic                 lt, eq;
    logic [DATAWIDTH-1:0] opb, sum;
    logic                 lt_c, eq_c;
    logic [DATAWIDTH-1:0] g_c, h_c, x_full, z_full;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        op         = OP_ADD;
        sel_c      = 1'b0;
        case (state)
            IDLE:    if (start) next_state = S_D;
            S_D:     next_state = S_E;
            S_E:     begin
                         sel_c      = 1'b1;
                         next_state = S_F;
                     end
            S_F:     begin
                         op         = OP_SUB;
                         next_state = S_CMP;
                     end
            S_CMP:   next_state = S_OUT;
            S_OUT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign opb = sel_c ? rc : rb;

    addsub #(.DATAWIDTH(DATAWIDTH)) u_addsub (
        .opa (ra),
        .opb (opb),
        .op  (op),
        .res (sum)
    );

    // Comparator and selects look only at the registered d/e/f
    always_comb begin
        lt_c   = (d < e);
        eq_c   = (d == e);
        g_c    = lt_c ? e : d;
        h_c    = eq_c ? f : g_c;
        x_full = h << lt;
        z_full = g << eq;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ra   <= '0;
            rb   <= '0;
            rc   <= '0;
            d    <= '0;
            e    <= '0;
            f    <= '0;
            g    <= '0;
            h    <= '0;
            lt   <= 1'b0;
            eq   <= 1'b0;
            x    <= '0;
            z    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ra <= a;
                    rb <= b;
                    rc <= c;
                end
                S_D:   d <= sum;
                S_E:   e <= sum;
                S_F:   f <= sum;
                S_CMP: begin
                    lt <= lt_c;
                    eq <= eq_c;
                    g  <= g_c;
                    h  <= h_c;
                end
                S_OUT: begin
                    x    <= x_full[OUTWIDTH-1:0];
                    z    <= z_full[OUTWIDTH-1:0];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
